// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared types and constants for the USB transmit sequencer.
//   tx_state_t      sequencer state encoding (CRC state only with USB_TX_CRC16_EN)
//   SYNC_DEFAULT    default SYNC byte, sent LSB-first
//   CRC16_*         CRC16 polynomial (normal form), seed and good-packet residual
//   reflect16()     bit-reverses a 16-bit value (used to build the LSB-first polynomial)
package usb_tx_pkg;

   localparam int BYTE_W    = 8;
   localparam int IDX_W     = 3;
   localparam int EOP_CNT_W = 3;
   localparam int CRC_W     = 16;

   localparam logic [BYTE_W-1:0] SYNC_DEFAULT   = 8'h80;
   localparam logic [CRC_W-1:0]  CRC16_POLY     = 16'h8005;
   localparam logic [CRC_W-1:0]  CRC16_SEED     = 16'hFFFF;
   localparam logic [CRC_W-1:0]  CRC16_RESIDUAL = 16'h800D;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SYNC = 3'd1,
      S_DATA = 3'd2,
`ifdef USB_TX_CRC16_EN
      S_CRC  = 3'd3,
`endif
      S_EOP  = 3'd4,
      S_DONE = 3'd5
   } tx_state_t;

   function automatic logic [CRC_W-1:0] reflect16(input logic [CRC_W-1:0] v);
      logic [CRC_W-1:0] r;
      r = '0;
      for (int i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
      return r;
   endfunction

endpackage

// File: rtl/usb_tx_ctrl_crc16.sv
// crc16_serial: bit-serial CRC16 in LSB-first (reflected) form.
//   clk, rst_L  clock, async active-low reset (register goes to seed)
//   clr         reload the seed
//   en          absorb din this cycle
//   din         serial data bit
//   crc         current CRC register
// Feeding din = crc[0] makes the feedback zero, so the register simply
// shifts right; the controller uses this to serialise the CRC itself.
module crc16_serial
   import usb_tx_pkg::*;
(
   input  logic             clk,
   input  logic             rst_L,
   input  logic             clr,
   input  logic             en,
   input  logic             din,
   output logic [CRC_W-1:0] crc
);

   localparam logic [CRC_W-1:0] POLY_R = reflect16(CRC16_POLY);

   logic fb;
   assign fb = crc[0] ^ din;

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L)   crc <= CRC16_SEED;
      else if (clr) crc <= CRC16_SEED;
      else if (en)  crc <= (crc >> 1) ^ (fb ? POLY_R : '0);
   end

endmodule

// File: rtl/usb_tx_ctrl.sv
// usb_tx_ctrl: transmit sequencer feeding the serial bit stuffer.
// Emits SYNC, then packet bytes LSB-first, optionally CRC16 (build with
// USB_TX_CRC16_EN), then EOP_BITS cycles of SE0 and a done pulse.
//   clk, rst_L     clock, async active-low reset
//   start          begin a packet (only looked at in IDLE)
//   byte_in/valid/last, byte_ready   byte handshake (ready is combinational)
//   stuff_bit      bit to the stuffer; stuff_pause holds it
//   se0            EOP single-ended zero
//   busy, done, err_underrun         status
module usb_tx_ctrl
   import usb_tx_pkg::*;
#(
   parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_DEFAULT,
   parameter int                EOP_BITS  = 2
) (
   input  logic              clk,
   input  logic              rst_L,
   input  logic              start,
   input  logic [BYTE_W-1:0] byte_in,
   input  logic              byte_valid,
   input  logic              byte_last,
   output logic              byte_ready,
   output logic              stuff_bit,
   input  logic              stuff_pause,
   output logic              se0,
   output logic              busy,
   output logic              done,
   output logic              err_underrun
);

   localparam logic [IDX_W-1:0]     IDX_LAST = '1;
   localparam logic [EOP_CNT_W-1:0] EOP_END  = EOP_CNT_W'(EOP_BITS - 1);

   tx_state_t             state, state_nx;
   logic [BYTE_W-1:0]     sh, sh_nx;
   logic [IDX_W-1:0]      idx, idx_nx;
   logic [EOP_CNT_W-1:0]  eop_cnt, eop_cnt_nx;
   logic                  last_seen, last_nx;

`ifdef USB_TX_CRC16_EN
   logic             crc_clr, crc_en, crc_din;
   logic             crc_hi, crc_hi_nx;  // second CRC byte in flight
   logic [CRC_W-1:0] crc;

   crc16_serial u_crc (
      .clk(clk), .rst_L(rst_L), .clr(crc_clr), .en(crc_en), .din(crc_din), .crc(crc)
   );
`endif

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         state     <= S_IDLE;
         sh        <= '0;
         idx       <= '0;
         eop_cnt   <= '0;
         last_seen <= 1'b0;
`ifdef USB_TX_CRC16_EN
         crc_hi    <= 1'b0;
`endif
      end else begin
         state     <= state_nx;
         sh        <= sh_nx;
         idx       <= idx_nx;
         eop_cnt   <= eop_cnt_nx;
         last_seen <= last_nx;
`ifdef USB_TX_CRC16_EN
         crc_hi    <= crc_hi_nx;
`endif
      end
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

   always_comb begin
      state_nx     = state;
      sh_nx        = sh;
      idx_nx       = idx;
      eop_cnt_nx   = eop_cnt;
      last_nx      = last_seen;
      byte_ready   = 1'b0;
      err_underrun = 1'b0;
      stuff_bit    = 1'b0;
      se0          = 1'b0;
`ifdef USB_TX_CRC16_EN
      crc_clr      = 1'b0;
      crc_en       = 1'b0;
      crc_din      = sh[0];
      crc_hi_nx    = crc_hi;
`endif
      case (state)
         S_IDLE: begin
            if (start) begin
               sh_nx      = SYNC_BYTE;
               idx_nx     = '0;
               eop_cnt_nx = '0;
               last_nx    = 1'b0;
               state_nx   = S_SYNC;
`ifdef USB_TX_CRC16_EN
               crc_clr    = 1'b1;
               crc_hi_nx  = 1'b0;
`endif
            end
         end
         S_SYNC, S_DATA: begin
            stuff_bit  = sh[0];
            byte_ready = (idx == IDX_LAST) && !stuff_pause && !last_seen;
            if (!stuff_pause) begin
               sh_nx  = sh >> 1;
               idx_nx = idx + 1'b1;
`ifdef USB_TX_CRC16_EN
               crc_en = (state == S_DATA);  // SYNC bits stay out of the CRC
`endif
               if (idx == IDX_LAST) begin
                  if (byte_ready) begin
                     if (byte_valid) begin
                        sh_nx    = byte_in;
                        idx_nx   = '0;
                        last_nx  = byte_last;
                        state_nx = S_DATA;
                     end else begin
                        // Nothing to send: abort straight into EOP, no CRC.
                        err_underrun = 1'b1;
                        state_nx     = S_EOP;
                     end
                  end else begin
`ifdef USB_TX_CRC16_EN
                     state_nx = S_CRC;
`else
                     state_nx = S_EOP;
`endif
                  end
               end
            end
         end
`ifdef USB_TX_CRC16_EN
         S_CRC: begin
            stuff_bit = ~crc[0];
            if (!stuff_pause) begin
               crc_en  = 1'b1;
               crc_din = crc[0];  // zero feedback: plain right shift
               idx_nx  = idx + 1'b1;
               if (idx == IDX_LAST) begin
                  if (crc_hi) state_nx  = S_EOP;
                  else        crc_hi_nx = 1'b1;
               end
            end
         end
`endif
         S_EOP: begin
            // A pending stuffed 0 goes out before SE0 starts.
            se0 = !stuff_pause;
            if (se0) begin
               eop_cnt_nx = eop_cnt + 1'b1;
               if (eop_cnt == EOP_END) state_nx = S_DONE;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_usb_tx_ctrl.sv
// Scoreboard bench for usb_tx_ctrl: stimulus pushes the expected wire bit
// stream and per-packet summary; a negedge monitor pops and compares.
// A looped-back bit-stuffer model drives stuff_pause.
module tb_usb_tx_ctrl;
   import usb_tx_pkg::*;

   localparam int EOP_BITS = 2;

   logic       clk = 1'b0, rst_L = 1'b0, start = 1'b0;
   logic [7:0] byte_in = 8'h00;
   logic       byte_valid = 1'b0, byte_last = 1'b0, stuff_pause = 1'b0;
   logic       byte_ready, stuff_bit, se0, busy, done, err_underrun;

   usb_tx_ctrl #(.SYNC_BYTE(8'h80), .EOP_BITS(EOP_BITS)) dut (
      .clk(clk), .rst_L(rst_L), .start(start), .byte_in(byte_in),
      .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(byte_ready),
      .stuff_bit(stuff_bit), .stuff_pause(stuff_pause), .se0(se0),
      .busy(busy), .done(done), .err_underrun(err_underrun)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_err = 0;

   typedef struct {
      int base_cyc;
      int nready;
      int nund;
      bit crc_sent;
   } pkt_t;

   bit         exp_bits[$];
   pkt_t       exp_pkt[$];
   logic [7:0] pkt_bytes[$];
   bit         mon_en = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Normal-form (MSB-first register) CRC16 over bits in wire order.
   function automatic logic [15:0] crc_step(input logic [15:0] r, input bit b);
      logic fb;
      fb = r[15] ^ b;
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h8005;
      return r;
   endfunction

   // Reference model: wire bits and timing follow from packet content alone.
   task automatic push_pkt(input int und_at);
      int          nacc;
      logic [15:0] r;
      logic [7:0]  sync_v, bv;
      pkt_t        p;
      bit          with_crc;
      nacc   = (und_at >= 0) ? und_at : pkt_bytes.size();
      sync_v = 8'h80;
      for (int i = 0; i < 8; i++) exp_bits.push_back(sync_v[i]);
      r = 16'hFFFF;
      for (int k = 0; k < nacc; k++) begin
         bv = pkt_bytes[k];
         for (int i = 0; i < 8; i++) begin
            exp_bits.push_back(bv[i]);
            r = crc_step(r, bv[i]);
         end
      end
      with_crc = 1'b0;
`ifdef USB_TX_CRC16_EN
      with_crc = (und_at < 0);
`endif
      if (with_crc) for (int i = 15; i >= 0; i--) exp_bits.push_back(~r[i]);
      p.base_cyc = 1 + 8 + 8 * nacc + (with_crc ? 16 : 0) + EOP_BITS;
      p.nready   = (und_at >= 0) ? und_at + 1 : pkt_bytes.size();
      p.nund     = (und_at >= 0) ? 1 : 0;
      p.crc_sent = with_crc;
      exp_pkt.push_back(p);
   endtask

   // Monitor
   int          t, npause, nready, nund, nse0, nbits;
   bit          prev_busy = 1'b0, prev_done = 1'b0, mon_b;
   logic [15:0] res;
   pkt_t        mon_p;

   always @(negedge clk) begin
      if (!rst_L || !mon_en) begin
         prev_busy = 1'b0;
         prev_done = 1'b0;
      end else begin
         if (prev_done) chk("busy_after_done", busy, 0);
         if (!busy) chk("idle_outputs", {stuff_bit, se0, byte_ready, done, err_underrun}, 0);
         if (busy && !prev_busy) begin
            t = 1; npause = 0; nready = 0; nund = 0; nse0 = 0; nbits = 0; res = 16'hFFFF;
         end else if (busy) t++;
         if (busy) begin
            if (!done && stuff_pause) npause++;
            if (byte_ready) nready++;
            if (err_underrun) nund++;
            if (se0) nse0++;
            if (!done && !stuff_pause && !se0) begin
               n_chk++;
               if (exp_bits.size() == 0) begin
                  n_err++;
                  $display("FAIL stuff_bit: extra bit %0b with nothing expected at %0t", stuff_bit, $time);
               end else begin
                  n_chk--;
                  mon_b = exp_bits.pop_front();
                  chk("stuff_bit", stuff_bit, mon_b);
               end
               nbits++;
               if (nbits > 8) res = crc_step(res, stuff_bit);
            end
            if (done) begin
               n_chk++;
               if (exp_pkt.size() == 0) begin
                  n_err++;
                  $display("FAIL done: unexpected done pulse at %0t", $time);
               end else begin
                  n_chk--;
                  mon_p = exp_pkt.pop_front();
                  chk("done_cycle", t, mon_p.base_cyc + npause);
                  chk("ready_cnt", nready, mon_p.nready);
                  chk("underrun_cnt", nund, mon_p.nund);
                  chk("se0_cnt", nse0, EOP_BITS);
                  chk("bits_left", exp_bits.size(), 0);
                  if (mon_p.crc_sent) chk("crc_residual", res, CRC16_RESIDUAL);
               end
            end
         end
         prev_busy = busy;
         prev_done = done;
      end
   end

   task automatic drive_byte(input int fi, input int und_at);
      int n;
      n          = pkt_bytes.size();
      byte_in    = (fi < n) ? pkt_bytes[fi] : 8'h00;
      byte_valid = (fi < n) && (fi != und_at);
      byte_last  = (fi == n - 1);
   endtask

   // Sends pkt_bytes; the bench's stuffer inserts a 0 after six ones.
   task automatic send_pkt(input int und_at, input bit rnd_pause, input bit rnd_start);
      int fi, ones;
      bit acc, got_done;
      fi = 0; ones = 0; got_done = 1'b0;
      push_pkt(und_at);
      @(posedge clk); #1;
      start = 1'b1;
      drive_byte(fi, und_at);
      for (int c = 0; c < 3000 && !got_done; c++) begin
         @(negedge clk);
         acc      = byte_ready & byte_valid;
         got_done = done;
         if (stuff_pause || se0) ones = 0;
         else if (stuff_bit)     ones++;
         else                    ones = 0;
         @(posedge clk); #1;
         start       = rnd_start && !got_done && ($urandom_range(0, 5) == 0);
         stuff_pause = !got_done && ((ones == 6) || (rnd_pause && $urandom_range(0, 4) == 0));
         if (acc) fi++;
         drive_byte(fi, und_at);
      end
      start = 1'b0; stuff_pause = 1'b0; byte_valid = 1'b0;
      if (!got_done) begin
         n_chk++; n_err++;
         $display("FAIL timeout: no done within 3000 cycles");
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #12;
      chk("rst_stuff_bit", stuff_bit, 0);
      chk("rst_se0", se0, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_underrun", err_underrun, 0);
      chk("rst_byte_ready", byte_ready, 0);
      @(posedge clk); #1; rst_L = 1'b1;
      repeat (2) @(posedge clk);

      pkt_bytes = '{8'hA5};        send_pkt(-1, 1'b0, 1'b0);
      pkt_bytes = '{8'hFF, 8'h01}; send_pkt(-1, 1'b0, 1'b0);
      pkt_bytes = '{8'hFC};        send_pkt(-1, 1'b0, 1'b0);
      pkt_bytes = '{8'h3C, 8'h12}; send_pkt(0, 1'b0, 1'b0);
      pkt_bytes = '{8'h00, 8'h01}; send_pkt(-1, 1'b0, 1'b0);

      // Asynchronous reset in the middle of a data byte.
      mon_en = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; byte_in = 8'h55; byte_valid = 1'b1; byte_last = 1'b0;
      @(posedge clk); #1; start = 1'b0;
      repeat (12) @(posedge clk);
      #3; rst_L = 1'b0; #1;
      chk("mid_rst_stuff_bit", stuff_bit, 0);
      chk("mid_rst_se0", se0, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_underrun", err_underrun, 0);
      chk("mid_rst_byte_ready", byte_ready, 0);
      @(posedge clk); #1;
      rst_L = 1'b1; byte_valid = 1'b0;
      exp_bits.delete(); exp_pkt.delete();
      mon_en = 1'b1;
      pkt_bytes = '{8'h00}; send_pkt(-1, 1'b0, 1'b0);

      for (int p = 0; p < 25; p++) begin
         int n, und;
         n = $urandom_range(1, 4);
         pkt_bytes.delete();
         for (int k = 0; k < n; k++)
            pkt_bytes.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
         und = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         send_pkt(und, 1'($urandom_range(0, 1)), 1'b1);
      end

      chk("queues_empty", exp_bits.size() + exp_pkt.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
